// File: rtl/vm_cfg_pkg.sv
// Shared definitions for the APB configuration loader: FSM states, error codes
// and the fixed register map used by the loader and its transfer engine.
package vm_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_CNT   = 4'd1,
        ST_FETCH    = 4'd2,
        ST_WAIT_SRC = 4'd3,
        ST_WRITE    = 4'd4,
        ST_READ     = 4'd5,
        ST_CHECK    = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERR      = 4'd8
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_COUNT    = 2'd3;

    localparam logic [14:0] CNT_REG_ADDR = 15'h0000;

    // Item k lives one word above the count register: byte address (k+1)*4.
    function automatic logic [14:0] item_addr(input logic [14:0] idx);
        return (idx + 15'd1) << 2'd2;
    endfunction

endpackage

// File: rtl/apb_xfer_engine.sv
// Single-outstanding APB transfer sequencer: holds the request stable until
// pready, captures read data on that edge and aborts after a bounded wait.
module apb_xfer_engine #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_write,
    input  logic [14:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        xfer_done,
    output logic        xfer_timeout,
    output logic [31:0] rdata,
    output logic        psel,
    output logic        pwrite,
    output logic [14:0] paddr,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic [31:0] prdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt_r;

    // pready only counts while a transfer is open; a completion beats a timeout.
    assign xfer_done    = psel & pready;
    assign xfer_timeout = psel & ~pready & (wait_cnt_r == TO_LAST);

    // Transfer register: launch, hold, complete or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            psel       <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= 15'd0;
            pwdata     <= 32'd0;
            rdata      <= 32'd0;
            wait_cnt_r <= '0;
        end else if (!psel && req) begin
            psel       <= 1'b1;
            pwrite     <= req_write;
            paddr      <= req_addr;
            pwdata     <= req_wdata;
            wait_cnt_r <= '0;
        end else if (xfer_done) begin
            psel <= 1'b0;
            if (!pwrite) begin
                rdata <= prdata;
            end else begin
                rdata <= rdata;
            end
        end else if (xfer_timeout) begin
            psel <= 1'b0;
        end else if (psel) begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

endmodule

// File: rtl/apb_cfg_loader.sv
// Streams item_count words from an item source into an APB register block,
// preceded by a count register write, with optional per-item readback check.
module apb_cfg_loader
    import vm_cfg_pkg::*;
#(
    parameter int MAX_ITEMS  = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_apb,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  verify,
    input  logic [ADDR_WIDTH:0]   item_count,
    output logic                  src_req,
    output logic [ADDR_WIDTH-1:0] src_idx,
    input  logic                  src_valid,
    input  logic [31:0]           src_data,
    output logic [14:0]           paddr,
    output logic                  psel,
    output logic                  pwrite,
    output logic [31:0]           pwdata,
    output logic                  cfg_mode,
    input  logic [31:0]           prdata,
    input  logic                  pready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] err_index
);

    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH + 1)'(MAX_ITEMS);

    state_t                state_r, state_next;
    logic [ADDR_WIDTH-1:0] i_r, i_next_s;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  verify_r;
    logic [31:0]           word_r;

    logic                  accept_s;
    logic                  cap_word_s;
    logic                  set_err_s;
    logic [1:0]            err_code_s;
    logic [ADDR_WIDTH-1:0] err_idx_s;
    logic                  last_s;

    logic                  xfer_req_s;
    logic                  xfer_write_s;
    logic [14:0]           xfer_addr_s;
    logic [31:0]           xfer_wdata_s;
    logic                  xfer_done_s;
    logic                  xfer_timeout_s;
    logic [31:0]           rdata_s;

    assign last_s = (({1'b0, i_r} + (ADDR_WIDTH + 1)'(1)) == count_r);

    apb_xfer_engine #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk          (clk_apb),
        .rst          (rst),
        .req          (xfer_req_s),
        .req_write    (xfer_write_s),
        .req_addr     (xfer_addr_s),
        .req_wdata    (xfer_wdata_s),
        .xfer_done    (xfer_done_s),
        .xfer_timeout (xfer_timeout_s),
        .rdata        (rdata_s),
        .psel         (psel),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pready       (pready),
        .prdata       (prdata)
    );

    // Next-state logic and APB request generation.
    always_comb begin
        state_next   = state_r;
        i_next_s     = i_r;
        accept_s     = 1'b0;
        cap_word_s   = 1'b0;
        set_err_s    = 1'b0;
        err_code_s   = ERR_NONE;
        err_idx_s    = i_r;
        xfer_req_s   = 1'b0;
        xfer_write_s = 1'b1;
        xfer_addr_s  = item_addr(15'(i_r));
        xfer_wdata_s = word_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    i_next_s = '0;
                    if (item_count > MAX_CNT) begin
                        state_next = ST_ERR;
                        set_err_s  = 1'b1;
                        err_code_s = ERR_COUNT;
                        err_idx_s  = '0;
                    end else begin
                        state_next = ST_WR_CNT;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WR_CNT: begin
                xfer_req_s   = ~psel;
                xfer_addr_s  = CNT_REG_ADDR;
                xfer_wdata_s = 32'(count_r);
                if (xfer_done_s) begin
                    state_next = (count_r == '0) ? ST_DONE : ST_FETCH;
                end else if (xfer_timeout_s) begin
                    state_next = ST_ERR;
                    set_err_s  = 1'b1;
                    err_code_s = ERR_TIMEOUT;
                end else begin
                    state_next = ST_WR_CNT;
                end
            end
            ST_FETCH: begin
                state_next = ST_WAIT_SRC;
            end
            ST_WAIT_SRC: begin
                if (src_valid) begin
                    cap_word_s = 1'b1;
                    state_next = ST_WRITE;
                end else begin
                    state_next = ST_WAIT_SRC;
                end
            end
            ST_WRITE: begin
                xfer_req_s = ~psel;
                if (xfer_done_s) begin
                    if (verify_r) begin
                        state_next = ST_READ;
                    end else if (last_s) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_FETCH;
                        i_next_s   = i_r + ADDR_WIDTH'(1);
                    end
                end else if (xfer_timeout_s) begin
                    state_next = ST_ERR;
                    set_err_s  = 1'b1;
                    err_code_s = ERR_TIMEOUT;
                end else begin
                    state_next = ST_WRITE;
                end
            end
            ST_READ: begin
                xfer_req_s   = ~psel;
                xfer_write_s = 1'b0;
                if (xfer_done_s) begin
                    state_next = ST_CHECK;
                end else if (xfer_timeout_s) begin
                    state_next = ST_ERR;
                    set_err_s  = 1'b1;
                    err_code_s = ERR_TIMEOUT;
                end else begin
                    state_next = ST_READ;
                end
            end
            ST_CHECK: begin
                if (rdata_s != word_r) begin
                    state_next = ST_ERR;
                    set_err_s  = 1'b1;
                    err_code_s = ERR_MISMATCH;
                end else if (last_s) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_FETCH;
                    i_next_s   = i_r + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk_apb) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            i_r       <= '0;
            count_r   <= '0;
            verify_r  <= 1'b0;
            word_r    <= 32'd0;
            busy      <= 1'b0;
            cfg_mode  <= 1'b0;
            done      <= 1'b0;
            src_req   <= 1'b0;
            src_idx   <= '0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            err_index <= '0;
        end else begin
            state_r  <= state_next;
            i_r      <= i_next_s;
            busy     <= (state_next inside {ST_WR_CNT, ST_FETCH, ST_WAIT_SRC,
                                            ST_WRITE, ST_READ, ST_CHECK});
            cfg_mode <= (state_next inside {ST_WR_CNT, ST_FETCH, ST_WAIT_SRC,
                                            ST_WRITE, ST_READ, ST_CHECK});
            done     <= (state_next == ST_DONE);
            src_req  <= (state_next == ST_FETCH);
            if (state_next == ST_FETCH) begin
                src_idx <= i_next_s;
            end else begin
                src_idx <= src_idx;
            end
            if (accept_s) begin
                count_r  <= item_count;
                verify_r <= verify;
            end else begin
                count_r  <= count_r;
                verify_r <= verify_r;
            end
            if (cap_word_s) begin
                word_r <= src_data;
            end else begin
                word_r <= word_r;
            end
            // A fresh start clears the sticky error unless it fails itself.
            if (set_err_s) begin
                error     <= 1'b1;
                err_code  <= err_code_s;
                err_index <= err_idx_s;
            end else if (accept_s) begin
                error     <= 1'b0;
                err_code  <= ERR_NONE;
                err_index <= '0;
            end else begin
                error     <= error;
                err_code  <= err_code;
                err_index <= err_index;
            end
        end
    end

endmodule

// File: tb/tb_apb_cfg_loader.sv
// Randomized scoreboard bench for apb_cfg_loader with behavioural source,
// APB responder and a load-level reference model.
module tb_apb_cfg_loader;

    localparam int AW = 10;
    localparam int TO = 255;

    logic          clk_apb = 1'b0;
    logic          rst, start, verify;
    logic [AW:0]   item_count;
    logic          src_req, src_valid;
    logic [AW-1:0] src_idx;
    logic [31:0]   src_data;
    logic [14:0]   paddr;
    logic          psel, pwrite, cfg_mode, pready;
    logic [31:0]   pwdata, prdata;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [AW-1:0] err_index;

    always #5 clk_apb = ~clk_apb;

    apb_cfg_loader dut (
        .clk_apb(clk_apb), .rst(rst), .start(start), .verify(verify),
        .item_count(item_count), .src_req(src_req), .src_idx(src_idx),
        .src_valid(src_valid), .src_data(src_data), .paddr(paddr), .psel(psel),
        .pwrite(pwrite), .pwdata(pwdata), .cfg_mode(cfg_mode), .prdata(prdata),
        .pready(pready), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_index(err_index)
    );

    typedef struct { logic wr; logic [14:0] addr; logic [31:0] data; } xfer_t;
    typedef struct { logic is_err; logic [1:0] code; logic [AW-1:0] idx; } outcome_t;

    xfer_t    exp_xfers[$];
    outcome_t exp_out[$];
    int       n_checks = 0;
    int       n_fail = 0;
    int       src_req_seen = 0;

    logic [31:0] src_mem [0:1023];
    logic [31:0] apb_mem [0:1024];
    int          resp_delay = 2;
    bit          noise = 1'b0;
    bit          stall_en = 1'b0;
    logic [14:0] stall_addr = 15'd0;
    bit          corrupt_en = 1'b0;
    logic [14:0] corrupt_addr = 15'd0;
    int          last_psel_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic outcome_t mk_out(input logic e, input logic [1:0] c, input int idx);
        outcome_t o;
        o.is_err = e;
        o.code   = c;
        o.idx    = AW'(idx);
        return o;
    endfunction

    function automatic xfer_t mk_x(input logic wr, input int addr, input logic [31:0] d);
        xfer_t x;
        x.wr   = wr;
        x.addr = 15'(addr);
        x.data = d;
        return x;
    endfunction

    // Reference model: the transfer list and final outcome of one load.
    task automatic model_load(input int cnt, input bit ver, input int corrupt,
                              input int stall, output int fetches);
        fetches = 0;
        if (cnt > 1024) begin
            exp_out.push_back(mk_out(1'b1, 2'd3, 0));
            return;
        end
        exp_xfers.push_back(mk_x(1'b1, 0, 32'(cnt)));
        for (int k = 0; k < cnt; k++) begin
            fetches++;
            if (k == stall) begin
                exp_out.push_back(mk_out(1'b1, 2'd1, k));
                return;
            end
            exp_xfers.push_back(mk_x(1'b1, (k + 1) * 4, src_mem[k]));
            if (ver) begin
                exp_xfers.push_back(mk_x(1'b0, (k + 1) * 4, 32'd0));
                if (k == corrupt) begin
                    exp_out.push_back(mk_out(1'b1, 2'd2, k));
                    return;
                end
            end
        end
        exp_out.push_back(mk_out(1'b0, 2'd0, 0));
    endtask

    // APB responder: pready after a delay, memory-backed reads, optional stall/corruption.
    initial begin
        int cyc;
        int want;
        cyc = 0;
        want = 1;
        pready = 1'b0;
        prdata = 32'd0;
        forever begin
            @(posedge clk_apb); #1;
            pready = 1'b0;
            if (psel && !rst) begin
                cyc++;
                if (cyc == 1) want = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 4));
                if (!(stall_en && pwrite && paddr == stall_addr) && cyc == want) begin
                    pready = 1'b1;
                    if (pwrite) begin
                        apb_mem[paddr[14:2]] = pwdata;
                    end else begin
                        prdata = apb_mem[paddr[14:2]];
                        if (corrupt_en && paddr == corrupt_addr) prdata[0] = ~prdata[0];
                    end
                end
            end else begin
                if (cyc > 0) last_psel_len = cyc;
                cyc = 0;
                pready = noise && ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Item source: answers each src_req 1..3 cycles later; junk valids when idle.
    initial begin
        logic [AW-1:0] idx;
        src_valid = 1'b0;
        src_data = 32'd0;
        forever begin
            @(posedge clk_apb); #1;
            src_valid = 1'b0;
            if (src_req && !rst) begin
                idx = src_idx;
                repeat ($urandom_range(1, 3)) @(posedge clk_apb);
                #1;
                src_valid = 1'b1;
                src_data = src_mem[idx];
            end else if (noise && $urandom_range(0, 5) == 0) begin
                src_valid = 1'b1;
                src_data = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on every completed transfer and every outcome.
    initial begin
        xfer_t    x;
        outcome_t o;
        logic     error_q;
        error_q = 1'b0;
        forever begin
            @(negedge clk_apb);
            if (!rst) begin
                if (src_req) begin
                    chk("src_idx", 32'(src_idx), 32'(src_req_seen));
                    src_req_seen++;
                end
                if (psel && pready) begin
                    if (exp_xfers.size() == 0) begin
                        chk("xfer_unexpected", 32'(paddr), 32'hFFFF_FFFF);
                    end else begin
                        x = exp_xfers.pop_front();
                        chk("xfer_dir", 32'(pwrite), 32'(x.wr));
                        chk("xfer_addr", 32'(paddr), 32'(x.addr));
                        if (x.wr) chk("xfer_wdata", pwdata, x.data);
                    end
                end
                if (done || (error && !error_q)) begin
                    if (exp_out.size() == 0) begin
                        chk("outcome_unexpected", {30'd0, done, error}, 32'd0);
                    end else begin
                        o = exp_out.pop_front();
                        chk("outcome_is_err", 32'(error), 32'(o.is_err));
                        chk("outcome_done", 32'(done), 32'(!o.is_err));
                        chk("busy_at_outcome", 32'(busy), 32'd0);
                        if (o.is_err) begin
                            chk("err_code", 32'(err_code), 32'(o.code));
                            chk("err_index", 32'(err_index), 32'(o.idx));
                        end
                    end
                end
            end
            error_q = error;
        end
    end

    task automatic run_load(input int cnt, input bit ver, input int corrupt,
                            input int stall, input bit poke);
        int fetches;
        int budget;
        for (int k = 0; k < cnt && k < 1024; k++) src_mem[k] = $urandom;
        corrupt_en   = (corrupt >= 0);
        corrupt_addr = 15'((corrupt + 1) * 4);
        stall_en     = (stall >= 0);
        stall_addr   = 15'((stall + 1) * 4);
        model_load(cnt, ver, corrupt, stall, fetches);
        src_req_seen = 0;
        @(posedge clk_apb); #1;
        start = 1'b1;
        verify = ver;
        item_count = (AW + 1)'(cnt);
        @(posedge clk_apb); #1;
        start = 1'b0;
        verify = 1'($urandom);
        item_count = (AW + 1)'($urandom);
        if (cnt > 1024) begin
            chk("count_err_code", 32'(err_code), 32'd3);
            chk("count_err_busy", 32'(busy), 32'd0);
            chk("count_err_psel", 32'(psel), 32'd0);
        end else begin
            chk("busy_after_start", 32'(busy), 32'd1);
            chk("cfg_mode_after_start", 32'(cfg_mode), 32'd1);
        end
        if (poke && cnt >= 2) begin
            repeat (3) @(posedge clk_apb);
            #1;
            start = 1'b1;
            item_count = '0;
            @(posedge clk_apb); #1;
            start = 1'b0;
        end
        budget = 30 * cnt + TO + 200;
        for (int c = 0; c < budget && exp_out.size() != 0; c++) @(posedge clk_apb);
        repeat (3) @(posedge clk_apb);
        #1;
        chk("outcome_pending", 32'(exp_out.size()), 32'd0);
        chk("xfers_pending", 32'(exp_xfers.size()), 32'd0);
        chk("src_req_count", 32'(src_req_seen), 32'(fetches));
        chk("idle_psel", 32'(psel), 32'd0);
        if (stall >= 0) chk("timeout_psel_len", 32'(last_psel_len), 32'(TO));
        exp_out.delete();
        exp_xfers.delete();
        stall_en = 1'b0;
        corrupt_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fetches;
        int cnt;
        bit ver;
        bit hit;
        rst = 1'b1;
        start = 1'b0;
        verify = 1'b0;
        item_count = '0;
        repeat (3) @(posedge clk_apb);
        #1;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_src_req", 32'(src_req), 32'd0);
        chk("rst_cfg_mode", 32'(cfg_mode), 32'd0);
        rst = 1'b0;

        resp_delay = 2;
        run_load(3, 1'b0, -1, -1, 1'b0);
        run_load(2, 1'b1, 1, -1, 1'b0);
        run_load(0, 1'b0, -1, -1, 1'b0);
        run_load(1025, 1'b0, -1, -1, 1'b0);
        run_load(3, 1'b0, -1, 1, 1'b0);

        // Reset in the middle of the first item write.
        resp_delay = 4;
        for (int k = 0; k < 3; k++) src_mem[k] = $urandom;
        model_load(3, 1'b0, -1, -1, fetches);
        src_req_seen = 0;
        @(posedge clk_apb); #1;
        start = 1'b1;
        item_count = (AW + 1)'(3);
        @(posedge clk_apb); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (psel && pwrite && paddr == 15'h0004) hit = 1'b1;
            else begin
                @(posedge clk_apb); #1;
            end
        end
        chk("reach_item_write", 32'(hit), 32'd1);
        rst = 1'b1;
        @(posedge clk_apb); #1;
        exp_out.delete();
        exp_xfers.delete();
        chk("midrst_psel", 32'(psel), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_error", 32'(error), 32'd0);
        chk("midrst_cfg_mode", 32'(cfg_mode), 32'd0);
        rst = 1'b0;
        run_load(3, 1'b1, -1, -1, 1'b0);

        // Randomized loads with noise on pready/src_valid and ignored starts.
        noise = 1'b1;
        resp_delay = 0;
        for (int t = 0; t < 10; t++) begin
            cnt = $urandom_range(1, 12);
            ver = 1'($urandom);
            run_load(cnt, ver,
                     (ver && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt - 1)) : -1,
                     -1, 1'b1);
        end

        // Full-size load reaching the top address 0x1000.
        resp_delay = 1;
        run_load(1024, 1'b0, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
